// File: rtl/apb_reg_completer.sv
// apb_reg_completer: APB register-file completer with byte strobes, wait states and error reporting
module apb_reg_completer #(
    parameter int                       ADDR_WIDTH  = 32,
    parameter int                       DATA_WIDTH  = 32,
    parameter int                       NUM_REGS    = 16,
    parameter int                       WAIT_STATES = 2,
    parameter logic [NUM_REGS-1:0]      RO_MASK     = 16'h0001,
    parameter logic [DATA_WIDTH-1:0]    RESET_VAL   = 32'h0000_0000
) (
    input  logic                        pclk,
    input  logic                        preset,
    input  logic                        psel,
    input  logic                        penable,
    input  logic                        pwrite,
    input  logic [ADDR_WIDTH-1:0]       paddr,
    input  logic [DATA_WIDTH-1:0]       pwdata,
    input  logic [DATA_WIDTH/8-1:0]     pstrb,
    output logic [DATA_WIDTH-1:0]       prdata,
    output logic                        pready,
    output logic                        pslverr
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    typedef enum logic [1:0] {IDLE, ACCESS, ERR} state_t;
    state_t                     r_state, w_next;
    logic [3:0]                 r_cnt;
    logic [IDX_W-1:0]           r_idx;
    logic                       r_write, r_err;
    logic [DATA_WIDTH-1:0]      r_wdata;
    logic [DATA_WIDTH/8-1:0]    r_strb;
    logic [DATA_WIDTH-1:0]      r_regs [NUM_REGS];
    logic [ADDR_WIDTH-1:0]      w_word;
    logic [IDX_W-1:0]           w_idx;
    logic                       w_dec_err, w_setup, w_done;
    assign w_word    = paddr >> 2;
    assign w_idx     = paddr[IDX_W+1:2];
    assign w_dec_err = (paddr[1:0] != 2'b00) | (w_word >= ADDR_WIDTH'(NUM_REGS)) | (pwrite & RO_MASK[w_idx]);
    assign w_setup   = (r_state == IDLE) && psel && !penable;
    assign w_done    = (r_state == ACCESS) && psel && penable && (r_cnt == 4'd0);
    assign pready    = (r_state == ERR) | w_done;
    assign pslverr   = (r_state == ERR) | (w_done & r_err);
    assign prdata    = (w_done && !r_write && !r_err) ? r_regs[r_idx] : '0;
    // state register
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) r_state <= IDLE;
        else        r_state <= w_next;
    end
    // next state: missing setup or early deselect diverts to the one-cycle error response
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = !psel ? IDLE : (penable ? ERR : ACCESS);
            ACCESS:  w_next = !psel ? ERR : (w_done ? IDLE : ACCESS);
            default: w_next = IDLE;
        endcase
    end
    // setup-phase capture of the request and its decoded error, plus the wait-state countdown
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
        end else if (w_setup) begin
            r_cnt   <= 4'(WAIT_STATES);
            r_idx   <= w_idx;
            r_write <= pwrite;
            r_err   <= w_dec_err;
            r_wdata <= pwdata;
            r_strb  <= pstrb;
        end else if (r_state == ACCESS && psel && r_cnt != 4'd0) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end
    // register file: byte-lane writes only on an error-free write completion
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
        end else if (w_done && r_write && !r_err) begin
            for (int i = 0; i < DATA_WIDTH/8; i++)
                if (r_strb[i]) r_regs[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
    end
endmodule
